pico_gpio_port: RTL and testbench

//  Parametrised PicoBlaze I/O peripheral: WIDTH LED outputs and WIDTH switch inputs behind the

---
 rtl/pico_gpio_port.sv | 157 +++++++++++++++
 tb/tb_pico_gpio_port.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pico_gpio_port.sv
// pico_gpio_port: PicoBlaze (KCPSM) GPIO peripheral with WIDTH LED outputs and
// WIDTH switch inputs. The switches are synchronised, debounced and edge-detected,
// and they raise a maskable level interrupt.
// Register map (offset from BASE_ADDR, byte = offset[1:0]):
//   0-3 LED, 4-7 DEB (read only), 8-11 MASK, 12-15 PEND (write 1 to clear).
// Optional feature macro: PICO_GPIO_BOTH_EDGE_EN. When it is defined, PEND is set
// on both debounced edges. When it is undefined, PEND is set on rising edges only.
module pico_gpio_port #(
    parameter int          WIDTH           = 8,
    parameter logic [7:0]  BASE_ADDR       = 8'h00,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic             CLK_IN,
    input  logic             RESET_IN,
    input  logic [7:0]       PORT_ID,
    input  logic             WRITE_STROBE,
    input  logic             READ_STROBE,
    input  logic [7:0]       OUT_PORT,
    output logic [7:0]       IN_PORT,
    input  logic [WIDTH-1:0] SWITCHES,
    output logic [WIDTH-1:0] LEDS,
    output logic             INTERRUPT
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Select byte b of a zero-padded 32-bit register image.
    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] b);
        return word[{b, 3'b000} +: 8];
    endfunction

    // Reads have no side effects, so the strobe is not needed.
    logic rd_strobe_unused;
    assign rd_strobe_unused = READ_STROBE;

    logic [WIDTH-1:0]            led_q, led_d;
    logic [WIDTH-1:0]            mask_q, mask_d;
    logic [WIDTH-1:0]            pend_q, pend_d;
    logic [WIDTH-1:0]            deb_q, deb_d;
    logic [WIDTH-1:0]            sync1_q, sync2_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]                  in_q, in_d;

    logic             hit_s;
    logic             wr_s;
    logic [1:0]       grp_s;
    logic [1:0]       bsel_s;
    logic [4:0]       shamt_s;
    logic [WIDTH-1:0] wsel_s;
    logic [WIDTH-1:0] wdat_s;
    logic [WIDTH-1:0] w1c_s;
    logic [WIDTH-1:0] evt_s;

    // Address decode. Out-of-range byte lanes fall off when the value is truncated to WIDTH.
    always_comb begin
        hit_s   = (PORT_ID[7:4] == BASE_ADDR[7:4]);
        wr_s    = WRITE_STROBE & hit_s;
        grp_s   = PORT_ID[3:2];
        bsel_s  = PORT_ID[1:0];
        shamt_s = {bsel_s, 3'b000};
        wsel_s  = WIDTH'(32'h0000_00FF << shamt_s);
        wdat_s  = WIDTH'({24'h00_0000, OUT_PORT} << shamt_s);
    end

    // Per-bit debounce: a change must hold for DEBOUNCE_CYCLES cycles; any glitch restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge qualification of debounced changes, plus the write-1-to-clear mask.
    always_comb begin
`ifdef PICO_GPIO_BOTH_EDGE_EN
        evt_s = deb_d ^ deb_q;
`else
        evt_s = deb_d & ~deb_q;
`endif
        if (wr_s && (grp_s == 2'd3)) begin
            w1c_s = wdat_s & wsel_s;
        end else begin
            w1c_s = '0;
        end
    end

    // Register writes. For PEND, a new event takes priority over a simultaneous clear.
    always_comb begin
        led_d  = led_q;
        mask_d = mask_q;
        if (wr_s && (grp_s == 2'd0)) begin
            led_d = (led_q & ~wsel_s) | (wdat_s & wsel_s);
        end else begin
            led_d = led_q;
        end
        if (wr_s && (grp_s == 2'd2)) begin
            mask_d = (mask_q & ~wsel_s) | (wdat_s & wsel_s);
        end else begin
            mask_d = mask_q;
        end
        pend_d = (pend_q & ~w1c_s) | evt_s;
    end

    // Read mux. The result is registered, which gives the KCPSM INPUT one cycle of latency.
    always_comb begin
        logic [31:0] word_s;
        case (grp_s)
            2'd0:    word_s = 32'(led_q);
            2'd1:    word_s = 32'(deb_q);
            2'd2:    word_s = 32'(mask_q);
            2'd3:    word_s = 32'(pend_q);
            default: word_s = 32'h0000_0000;
        endcase
        if (hit_s) begin
            in_d = pick_byte(word_s, bsel_s);
        end else begin
            in_d = 8'h00;
        end
    end

    // State registers, cleared by the synchronous reset.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            led_q   <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            deb_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            in_q    <= 8'h00;
        end else begin
            led_q   <= led_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            deb_q   <= deb_d;
            sync1_q <= SWITCHES;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
        end
    end

    assign LEDS      = led_q;
    assign IN_PORT   = in_q;
    assign INTERRUPT = |(pend_q & mask_q);

endmodule

// File: tb/tb_pico_gpio_port.sv
// Directed self-checking bench for pico_gpio_port (WIDTH=12, BASE_ADDR=8'h10, DEBOUNCE_CYCLES=16).
module tb_pico_gpio_port;

`ifdef PICO_GPIO_BOTH_EDGE_EN
    localparam logic [7:0] FALL_PEND = 8'h01;
`else
    localparam logic [7:0] FALL_PEND = 8'h00;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  port_id;
    logic        wr_stb;
    logic        rd_stb;
    logic [7:0]  out_port;
    logic [7:0]  in_port;
    logic [11:0] switches;
    logic [11:0] leds;
    logic        irq;

    int total = 0;
    int bad   = 0;

    pico_gpio_port #(
        .WIDTH(12),
        .BASE_ADDR(8'h10),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .CLK_IN(clk),
        .RESET_IN(rst),
        .PORT_ID(port_id),
        .WRITE_STROBE(wr_stb),
        .READ_STROBE(rd_stb),
        .OUT_PORT(out_port),
        .IN_PORT(in_port),
        .SWITCHES(switches),
        .LEDS(leds),
        .INTERRUPT(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        port_id  = addr;
        out_port = data;
        wr_stb   = 1'b1;
        step(1);
        wr_stb   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        port_id = addr;
        step(1);
        check_val(tag, in_port, exp);
    endtask

    initial begin
        rst      = 1'b1;
        port_id  = 8'h00;
        wr_stb   = 1'b0;
        rd_stb   = 1'b0;
        out_port = 8'h00;
        switches = 12'hFFF;

        // 1: reset held with switches high
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_val("rst_leds", leds, 12'h000);
            check_val("rst_inport", in_port, 8'h00);
            check_val("rst_irq", irq, 1'b0);
        end

        // held-high switches give a fresh event exactly 18 edges after reset release
        rst     = 1'b0;
        port_id = 8'h14;
        step(18);
        check_val("rel_deb_before", in_port, 8'h00);
        step(1);
        check_val("rel_deb_after", in_port, 8'hFF);
        rd("rel_deb_hi", 8'h15, 8'h0F);
        rd("rel_pend_lo", 8'h1C, 8'hFF);
        rd("rel_pend_hi", 8'h1D, 8'h0F);
        check_val("rel_irq_masked", irq, 1'b0);
        switches = 12'h000;
        step(20);
        wr(8'h1C, 8'hFF);
        wr(8'h1D, 8'hFF);
        rd("clr_pend_lo", 8'h1C, 8'h00);
        rd("clr_pend_hi", 8'h1D, 8'h00);

        // 2: LED writes and read-back
        wr(8'h10, 8'hA5);
        check_val("led_lo", leds, 12'h0A5);
        wr(8'h11, 8'hFF);
        check_val("led_both", leds, 12'hFA5);
        rd("rd_led1", 8'h11, 8'h0F);
        rd("rd_led0", 8'h10, 8'hA5);
        rd("rd_led3", 8'h13, 8'h00);
        rd("rd_undec", 8'h20, 8'h00);
        wr(8'h20, 8'h00);
        wr(8'h12, 8'h33);
        check_val("led_ignored", leds, 12'hFA5);

        // 3: debounce latency
        switches = 12'h001;
        port_id  = 8'h14;
        step(18);
        check_val("deb_17", in_port, 8'h00);
        step(1);
        check_val("deb_18", in_port, 8'h01);
        rd("pend_rise", 8'h1C, 8'h01);
        check_val("irq_nomask", irq, 1'b0);

        // 6a: release of switch 0 (falling edge)
        wr(8'h1C, 8'h01);
        switches = 12'h000;
        step(20);
        rd("pend_fall", 8'h1C, FALL_PEND);
        wr(8'h1C, 8'h01);

        // 4: short pulse rejected, long pulse accepted
        switches = 12'h001;
        step(10);
        switches = 12'h000;
        step(25);
        rd("short_deb", 8'h14, 8'h00);
        rd("short_pend", 8'h1C, 8'h00);
        switches = 12'h001;
        step(20);
        switches = 12'h000;
        step(25);
        rd("long_pend", 8'h1C, 8'h01);
        rd("long_deb", 8'h14, 8'h00);

        // 5: mask, interrupt, write-1-to-clear, set beats clear
        wr(8'h1C, 8'h01);
        wr(8'h18, 8'h01);
        rd("mask_rd", 8'h18, 8'h01);
        check_val("irq_idle", irq, 1'b0);
        switches = 12'h001;
        step(17);
        check_val("irq_17", irq, 1'b0);
        step(1);
        check_val("irq_18", irq, 1'b1);
        wr(8'h1C, 8'h01);
        check_val("irq_w1c", irq, 1'b0);
        switches = 12'h000;
        step(20);
        wr(8'h1C, 8'h01);
        check_val("irq_fall_clr", irq, 1'b0);
        switches = 12'h001;
        step(17);
        wr(8'h1C, 8'h01);
        check_val("irq_set_wins", irq, 1'b1);
        rd("pend_set_wins", 8'h1C, 8'h01);

        // 6b: release switch 0 again, then an event on bit 11
        wr(8'h1C, 8'h01);
        switches = 12'h000;
        step(20);
        rd("pend_fall2", 8'h1C, FALL_PEND);
        wr(8'h1C, 8'h01);
        switches = 12'h800;
        step(20);
        rd("pend_b11", 8'h1D, 8'h08);
        rd("deb_b11", 8'h15, 8'h08);
        check_val("irq_b11_masked", irq, 1'b0);
        wr(8'h19, 8'hFF);
        check_val("irq_b11", irq, 1'b1);
        rd("mask_hi", 8'h19, 8'h0F);
        wr(8'h1D, 8'h08);
        check_val("irq_b11_clr", irq, 1'b0);

        // reset in mid-operation with bit 11 held high
        rst = 1'b1;
        step(2);
        check_val("mid_rst_leds", leds, 12'h000);
        check_val("mid_rst_irq", irq, 1'b0);
        rst     = 1'b0;
        port_id = 8'h15;
        step(18);
        check_val("mid_deb_17", in_port, 8'h00);
        step(1);
        check_val("mid_deb_18", in_port, 8'h08);
        rd("mid_pend", 8'h1D, 8'h08);
        rd("mid_mask", 8'h19, 8'h00);
        check_val("mid_irq", irq, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
